// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Constants shared by the architectural register file, issue and the reorder
// buffer: default tag width, register count, x0 index and operand width.
// Also provides a small helper that identifies the hard-wired zero register.
// -----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int ROB_BITS_DEFAULT = 4;
  localparam int NUM_REGS         = 32;
  localparam int REG_IDX_W        = 5;
  localparam int XLEN             = 32;

  localparam logic [REG_IDX_W-1:0] X0_IDX = 5'd0;

  // x0 has no storage: it never accepts writes or renames and always reads 0.
  function automatic logic is_x0(input logic [REG_IDX_W-1:0] idx);
    return (idx == X0_IDX);
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// -----------------------------------------------------------------------------
// reg_file_read_port
// One combinational source-operand port. Given the requested index, the stored
// entry for that index and this cycle's commit, it returns the operand as either
// a ready value or a pending producer tag. A commit that retires the current
// producer is forwarded so the operand is ready in the same cycle.
//
// Ports:
//   rs_id        in   5         source register index
//   ent_value    in   32        stored value of rs_id
//   ent_busy     in   1         stored busy bit of rs_id
//   ent_tag      in   ROB_BITS  stored producer tag of rs_id
//   commit_rd    in   5         destination of the retiring entry (0 = none)
//   commit_tag   in   ROB_BITS  tag of the retiring entry
//   commit_value in   32        retired value
//   rs_value     out  32        operand value (valid when rs_busy = 0)
//   rs_busy      out  1         operand still pending
//   rs_tag       out  ROB_BITS  producer tag (valid when rs_busy = 1)
// -----------------------------------------------------------------------------
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int ROB_BITS = ROB_BITS_DEFAULT
) (
  input  logic [REG_IDX_W-1:0] rs_id,
  input  logic [XLEN-1:0]      ent_value,
  input  logic                 ent_busy,
  input  logic [ROB_BITS-1:0]  ent_tag,
  input  logic [REG_IDX_W-1:0] commit_rd,
  input  logic [ROB_BITS-1:0]  commit_tag,
  input  logic [XLEN-1:0]      commit_value,
  output logic [XLEN-1:0]      rs_value,
  output logic                 rs_busy,
  output logic [ROB_BITS-1:0]  rs_tag
);

  logic w_fwd;

  // Forward only when the retiring entry is the register's newest producer;
  // an older producer retiring leaves the operand pending on the younger tag.
  assign w_fwd = (commit_rd == rs_id) && ent_busy && (ent_tag == commit_tag);

  // Operand select: x0, forwarded commit, pending producer, or stored value.
  always_comb begin
    rs_value = {XLEN{1'b0}};
    rs_busy  = 1'b0;
    rs_tag   = {ROB_BITS{1'b0}};
    if (is_x0(rs_id)) begin
      rs_value = {XLEN{1'b0}};
      rs_busy  = 1'b0;
      rs_tag   = {ROB_BITS{1'b0}};
    end else if (w_fwd) begin
      rs_value = commit_value;
      rs_busy  = 1'b0;
      rs_tag   = ent_tag;
    end else if (ent_busy) begin
      rs_value = ent_value;
      rs_busy  = 1'b1;
      rs_tag   = ent_tag;
    end else begin
      rs_value = ent_value;
      rs_busy  = 1'b0;
      rs_tag   = ent_tag;
    end
  end

endmodule

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// Architectural register file with rename tags: 32 x 32-bit registers, each
// with a busy bit and the reorder-buffer tag of its newest in-flight producer.
// Issue renames destinations, commit writes retired values and releases tags,
// and two combinational read ports return operands as values or pending tags.
//
// Ports:
//   clk_in        in   1         system clock
//   rst_in        in   1         synchronous active-high reset
//   rdy_in        in   1         global enable; low freezes all state
//   clear_in      in   1         pipeline flush: drops all busy bits and issue
//   issue_rd      in   5         destination being renamed (0 = none)
//   issue_tag     in   ROB_BITS  tag allocated to that destination
//   commit_rd     in   5         destination of retiring entry (0 = none)
//   commit_value  in   32        retired value
//   commit_tag    in   ROB_BITS  tag of retiring entry
//   rs1_id/rs2_id in   5         source indices
//   rs1_value/rs2_value out 32   operand values
//   rs1_busy/rs2_busy   out 1    operand pending
//   rs1_tag/rs2_tag     out ROB_BITS producer tags
// -----------------------------------------------------------------------------
module reg_file
  import reg_file_pkg::*;
#(
  parameter int ROB_BITS = ROB_BITS_DEFAULT
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_in,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic [ROB_BITS-1:0]  issue_tag,
  input  logic [REG_IDX_W-1:0] commit_rd,
  input  logic [XLEN-1:0]      commit_value,
  input  logic [ROB_BITS-1:0]  commit_tag,
  input  logic [REG_IDX_W-1:0] rs1_id,
  input  logic [REG_IDX_W-1:0] rs2_id,
  output logic [XLEN-1:0]      rs1_value,
  output logic [XLEN-1:0]      rs2_value,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [ROB_BITS-1:0]  rs1_tag,
  output logic [ROB_BITS-1:0]  rs2_tag
);

  // Entry 0 exists only to keep indexing uniform; it is never written and
  // the read ports ignore it.
  logic [XLEN-1:0]     r_value [NUM_REGS];
  logic [ROB_BITS-1:0] r_tag   [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;

  logic w_commit_en;
  logic w_commit_release;
  logic w_issue_en;

  assign w_commit_en      = rdy_in && !is_x0(commit_rd);
  assign w_commit_release = r_busy[commit_rd] && (r_tag[commit_rd] == commit_tag);
  assign w_issue_en       = rdy_in && !clear_in && !is_x0(issue_rd);

  // State update: commit first, then clear or issue. Later non-blocking
  // assignments win, so a same-register issue overrides the commit's busy
  // release and a flush overrides every busy bit while keeping the commit value.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_value[i] <= {XLEN{1'b0}};
        r_tag[i]   <= {ROB_BITS{1'b0}};
      end
      r_busy <= {NUM_REGS{1'b0}};
    end else begin
      if (w_commit_en) begin
        r_value[commit_rd] <= commit_value;
        if (w_commit_release) begin
          r_busy[commit_rd] <= 1'b0;
        end else begin
          r_busy[commit_rd] <= r_busy[commit_rd];
        end
      end else begin
        r_busy <= r_busy;
      end
      if (rdy_in && clear_in) begin
        r_busy <= {NUM_REGS{1'b0}};
      end else if (w_issue_en) begin
        r_busy[issue_rd] <= 1'b1;
        r_tag[issue_rd]  <= issue_tag;
      end else begin
        r_tag[issue_rd]  <= r_tag[issue_rd];
      end
    end
  end

  reg_file_read_port #(.ROB_BITS(ROB_BITS)) u_rd_port1 (
    .rs_id        (rs1_id),
    .ent_value    (r_value[rs1_id]),
    .ent_busy     (r_busy[rs1_id]),
    .ent_tag      (r_tag[rs1_id]),
    .commit_rd    (commit_rd),
    .commit_tag   (commit_tag),
    .commit_value (commit_value),
    .rs_value     (rs1_value),
    .rs_busy      (rs1_busy),
    .rs_tag       (rs1_tag)
  );

  reg_file_read_port #(.ROB_BITS(ROB_BITS)) u_rd_port2 (
    .rs_id        (rs2_id),
    .ent_value    (r_value[rs2_id]),
    .ent_busy     (r_busy[rs2_id]),
    .ent_tag      (r_tag[rs2_id]),
    .commit_rd    (commit_rd),
    .commit_tag   (commit_tag),
    .commit_value (commit_value),
    .rs_value     (rs2_value),
    .rs_busy      (rs2_busy),
    .rs_tag       (rs2_tag)
  );

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
// Directed self-checking bench for reg_file. Inputs change on the falling edge,
// outputs are sampled 1 time unit later, state updates on the rising edge.
// -----------------------------------------------------------------------------
module tb_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_tag;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [3:0]  commit_tag;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [3:0]  rs1_tag;
  logic [3:0]  rs2_tag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  reg_file #(.ROB_BITS(4)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear_in     (clear_in),
    .issue_rd     (issue_rd),
    .issue_tag    (issue_tag),
    .commit_rd    (commit_rd),
    .commit_value (commit_value),
    .commit_tag   (commit_tag),
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .rs1_value    (rs1_value),
    .rs2_value    (rs2_value),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .rs1_tag      (rs1_tag),
    .rs2_tag      (rs2_tag)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and land on the next falling edge.
  task automatic next_cycle();
    @(negedge clk_in);
  endtask

  task automatic idle_inputs();
    clear_in     = 1'b0;
    issue_rd     = 5'd0;
    issue_tag    = 4'd0;
    commit_rd    = 5'd0;
    commit_value = 32'd0;
    commit_tag   = 4'd0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [3:0] tag);
    issue_rd  = rd;
    issue_tag = tag;
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    rs1_id = 5'd0;
    rs2_id = 5'd0;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst_in = 1'b0;

    // Reset state
    rs1_id = 5'd5; rs2_id = 5'd31; #1;
    check_eq("rst_x5_val",   rs1_value, 32'd0);
    check_eq("rst_x5_busy",  {31'd0, rs1_busy}, 32'd0);
    check_eq("rst_x31_val",  rs2_value, 32'd0);
    check_eq("rst_x31_busy", {31'd0, rs2_busy}, 32'd0);

    // Rename x5 then commit it
    do_issue(5'd5, 4'd3);
    rs1_id = 5'd5; #1;
    check_eq("iss_x5_busy", {31'd0, rs1_busy}, 32'd1);
    check_eq("iss_x5_tag",  {28'd0, rs1_tag}, 32'd3);
    commit_rd = 5'd5; commit_tag = 4'd3; commit_value = 32'h1234; #1;
    check_eq("fwd_x5_busy", {31'd0, rs1_busy}, 32'd0);
    check_eq("fwd_x5_val",  rs1_value, 32'h1234);
    next_cycle();
    idle_inputs(); #1;
    check_eq("st_x5_busy", {31'd0, rs1_busy}, 32'd0);
    check_eq("st_x5_val",  rs1_value, 32'h1234);

    // Older producer retires while a younger one owns x7
    do_issue(5'd7, 4'd2);
    do_issue(5'd7, 4'd6);
    rs1_id = 5'd7; #1;
    check_eq("x7_tag6", {28'd0, rs1_tag}, 32'd6);
    commit_rd = 5'd7; commit_tag = 4'd2; commit_value = 32'd9; #1;
    check_eq("x7_old_nofwd_busy", {31'd0, rs1_busy}, 32'd1);
    next_cycle();
    idle_inputs(); #1;
    check_eq("x7_val9",   rs1_value, 32'd9);
    check_eq("x7_busy",   {31'd0, rs1_busy}, 32'd1);
    check_eq("x7_tag",    {28'd0, rs1_tag}, 32'd6);
    commit_rd = 5'd7; commit_tag = 4'd6; commit_value = 32'd11; #1;
    check_eq("x7_fwd_busy", {31'd0, rs1_busy}, 32'd0);
    check_eq("x7_fwd_val",  rs1_value, 32'd11);
    next_cycle();
    idle_inputs(); #1;
    check_eq("x7_st_busy", {31'd0, rs1_busy}, 32'd0);
    check_eq("x7_st_val",  rs1_value, 32'd11);

    // Same-cycle issue and matching commit on x4: read sees commit, state sees issue
    do_issue(5'd4, 4'd1);
    rs1_id = 5'd4;
    issue_rd = 5'd4; issue_tag = 4'd8;
    commit_rd = 5'd4; commit_tag = 4'd1; commit_value = 32'h55; #1;
    check_eq("x4_same_busy", {31'd0, rs1_busy}, 32'd0);
    check_eq("x4_same_val",  rs1_value, 32'h55);
    next_cycle();
    idle_inputs(); #1;
    check_eq("x4_next_busy", {31'd0, rs1_busy}, 32'd1);
    check_eq("x4_next_tag",  {28'd0, rs1_tag}, 32'd8);
    check_eq("x4_next_val",  rs1_value, 32'h55);

    // x0 ignores issue and commit
    rs1_id = 5'd0;
    issue_rd = 5'd0; issue_tag = 4'd5;
    commit_rd = 5'd0; commit_tag = 4'd0; commit_value = 32'hFFFF; #1;
    check_eq("x0_now_val",  rs1_value, 32'd0);
    check_eq("x0_now_busy", {31'd0, rs1_busy}, 32'd0);
    next_cycle();
    idle_inputs(); #1;
    check_eq("x0_next_val",  rs1_value, 32'd0);
    check_eq("x0_next_busy", {31'd0, rs1_busy}, 32'd0);

    // Flush with a retiring commit and a discarded issue
    do_issue(5'd1, 4'd1);
    do_issue(5'd2, 4'd2);
    do_issue(5'd3, 4'd3);
    rs1_id = 5'd2; rs2_id = 5'd3; #1;
    check_eq("pre_clr_x2_busy", {31'd0, rs1_busy}, 32'd1);
    check_eq("pre_clr_x3_busy", {31'd0, rs2_busy}, 32'd1);
    clear_in = 1'b1;
    commit_rd = 5'd1; commit_tag = 4'd1; commit_value = 32'h80;
    issue_rd = 5'd9; issue_tag = 4'd5;
    next_cycle();
    idle_inputs();
    rs1_id = 5'd1; rs2_id = 5'd9; #1;
    check_eq("clr_x1_val",  rs1_value, 32'h80);
    check_eq("clr_x1_busy", {31'd0, rs1_busy}, 32'd0);
    check_eq("clr_x9_busy", {31'd0, rs2_busy}, 32'd0);
    rs1_id = 5'd2; rs2_id = 5'd3; #1;
    check_eq("clr_x2_busy", {31'd0, rs1_busy}, 32'd0);
    check_eq("clr_x3_busy", {31'd0, rs2_busy}, 32'd0);

    // rdy_in low freezes state while reads stay live
    do_issue(5'd6, 4'd4);
    rs1_id = 5'd6; #1;
    check_eq("x6_busy", {31'd0, rs1_busy}, 32'd1);
    rdy_in = 1'b0;
    issue_rd = 5'd6; issue_tag = 4'd7;
    commit_rd = 5'd6; commit_tag = 4'd4; commit_value = 32'h66; #1;
    check_eq("x6_frz_fwd_busy", {31'd0, rs1_busy}, 32'd0);
    check_eq("x6_frz_fwd_val",  rs1_value, 32'h66);
    next_cycle();
    idle_inputs();
    rdy_in = 1'b1; #1;
    check_eq("x6_frz_busy", {31'd0, rs1_busy}, 32'd1);
    check_eq("x6_frz_tag",  {28'd0, rs1_tag}, 32'd4);
    check_eq("x6_frz_val",  rs1_value, 32'd0);

    // Reset mid-stream, with clear and issue active
    rst_in = 1'b1;
    clear_in = 1'b1;
    issue_rd = 5'd10; issue_tag = 4'd2;
    next_cycle();
    rst_in = 1'b0;
    idle_inputs();
    rs1_id = 5'd5; rs2_id = 5'd6; #1;
    check_eq("rst2_x5_val",  rs1_value, 32'd0);
    check_eq("rst2_x6_busy", {31'd0, rs2_busy}, 32'd0);
    rs1_id = 5'd10; rs2_id = 5'd4; #1;
    check_eq("rst2_x10_busy", {31'd0, rs1_busy}, 32'd0);
    check_eq("rst2_x4_val",   rs2_value, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
